// File: rtl/ifid_fetch_queue.sv
// In-order fetch queue between the IF and ID stages: DEPTH entries of {inst, pc, pc+PC_INC}.
// The fetch side uses a valid/ready handshake. The decode side has stall and flush.
module ifid_fetch_queue #(
  parameter int XLEN   = 32,
  parameter int ILEN   = 32,
  parameter int DEPTH  = 4,
  parameter int PC_INC = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ILEN-1:0]            in_inst,
  input  logic [XLEN-1:0]            in_pc,
  input  logic                       stall,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [ILEN-1:0]            out_inst,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_pc_plus4,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;

  // in_ready is a pure function of count, so stall and flush cannot reach it combinationally.
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & ~stall & ~flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset. Stale contents are hidden by the count-based gating on the outputs.
  always_ff @(posedge clk) begin
    if (rst_n && push)
      mem[wr_ptr] <= '{inst: in_inst, pc: in_pc, pc_plus4: in_pc + XLEN'(PC_INC)};
  end

  assign head         = mem[rd_ptr];
  assign out_inst     = out_valid ? head.inst     : '0;
  assign out_pc       = out_valid ? head.pc       : '0;
  assign out_pc_plus4 = out_valid ? head.pc_plus4 : '0;

endmodule

// File: tb/tb_ifid_fetch_queue.sv
// Bench for ifid_fetch_queue. A queue-based reference model is advanced once per cycle.
// The bench runs directed scenarios and then a randomized run.
module tb_ifid_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0, stall = 0, flush = 0;
  logic [31:0] in_inst = 0, in_pc = 0;
  logic        in_ready, out_valid;
  logic [31:0] out_inst, out_pc, out_pc_plus4;
  logic [2:0]  count;

  ifid_fetch_queue #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH), .PC_INC(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .out_pc_plus4(out_pc_plus4), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] inst, pc, p4; } ent_t;
  ent_t q[$];
  int   n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    bit   v;
    ent_t h;
    v = (q.size() != 0);
    h = v ? q[0] : '{0, 0, 0};
    chk("out_valid", 64'(out_valid), 64'(v));
    chk("out_inst", 64'(out_inst), 64'(h.inst));
    chk("out_pc", 64'(out_pc), 64'(h.pc));
    chk("out_pc_plus4", 64'(out_pc_plus4), 64'(h.p4));
    chk("count", 64'(count), 64'(q.size()));
    chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
  endtask

  // One cycle: check the current outputs, drive the inputs, clock, then update the model.
  task automatic step(input bit rst, input bit v, input logic [31:0] inst, input logic [31:0] pc,
                      input bit stl, input bit fl);
    bit do_push, do_pop;
    check_outputs();
    rst_n = ~rst; in_valid = v; in_inst = inst; in_pc = pc; stall = stl; flush = fl;
    do_push = v && (q.size() < DEPTH) && !fl;
    do_pop  = (q.size() != 0) && !stl && !fl;
    @(posedge clk);
    if (rst || fl) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{inst, pc, pc + 32'd4});
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit stl);
    step(0, 0, 32'hDEAD_BEEF, 32'hBAD0_BAD0, stl, 0);
  endtask

  initial begin
    @(negedge clk);
    step(1, 1, 32'h1111, 32'h40, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_ready", 64'(in_ready), 64'd1);

    // Single push: visible one cycle later, then gone.
    step(0, 1, 32'h0050_0093, 32'h100, 0, 0);
    chk("single_inst", 64'(out_inst), 64'h0050_0093);
    chk("single_p4", 64'(out_pc_plus4), 64'h104);
    idle(0);
    idle(0);

    // Fill under stall: the fifth push is refused.
    for (int i = 0; i < 5; i++) step(0, 1, 32'hA000 + i, 32'(i * 4), 1, 0);
    chk("full_ready", 64'(in_ready), 64'd0);
    chk("full_head", 64'(out_pc), 64'h0);
    idle(1);
    for (int i = 0; i < 5; i++) idle(0);

    // Steady state push+pop at count=2 through several pointer wraps.
    step(0, 1, 32'hB000, 32'h1000, 1, 0);
    step(0, 1, 32'hB001, 32'h1004, 1, 0);
    for (int i = 2; i < 16; i++) step(0, 1, 32'hB000 + i, 32'h1000 + 32'(i * 4), 0, 0);
    chk("steady_count", 64'(count), 64'd2);
    idle(0); idle(0); idle(0);

    // Flush with a valid input and stall both asserted.
    for (int i = 0; i < 3; i++) step(0, 1, 32'hC000 + i, 32'h300 + 32'(i * 4), 1, 0);
    step(0, 1, 32'hC0FF, 32'h3FC, 1, 1);
    chk("flush_valid", 64'(out_valid), 64'd0);
    step(0, 1, 32'hC200, 32'h200, 0, 0);
    chk("post_flush_pc", 64'(out_pc), 64'h200);
    idle(0);

    // pc_plus4 wraps modulo 2^32.
    step(0, 1, 32'hD000, 32'hFFFF_FFFC, 0, 0);
    chk("wrap_p4", 64'(out_pc_plus4), 64'h0);
    idle(0);

    // Reset mid-operation drops the queued entries.
    step(0, 1, 32'hE000, 32'h500, 1, 0);
    step(0, 1, 32'hE001, 32'h504, 1, 0);
    step(1, 1, 32'hE002, 32'h508, 0, 0);
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    idle(0); idle(0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 99) == 0), $urandom_range(0, 3) != 0, $urandom, $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0);
    check_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ifid_fetch_queue.md
Name: ifid_fetch_queue

Overview:
- Parametrised successor to the single-entry IF/ID register: a DEPTH-entry in-order fetch queue between the fetch and decode stages.
- Decouples instruction-memory fetch from decode stalls.
- Carries inst, pc and pc+PC_INC per entry.
- Adds valid/ready handshake on the fetch side, a stall/flush interface on the decode side, and an occupancy count.

Parameters:
- XLEN, 32, PC width in bits.
- ILEN, 32, instruction width in bits.
- DEPTH, 4, queue entries; power of two, >= 2.
- PC_INC, 4, increment stored as pc_plus4.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept an entry (count != DEPTH).
- in_inst  in  ILEN  fetched instruction.
- in_pc  in  XLEN  PC of fetched instruction.
- stall  in  1  decode holds head entry (StallD).
- flush  in  1  discard all entries (FlushD, branch/jump redirect).
- out_valid  out  1  head entry valid (count != 0).
- out_inst  out  ILEN  head instruction; 0 when !out_valid.
- out_pc  out  XLEN  head PC; 0 when !out_valid.
- out_pc_plus4  out  XLEN  head PC+PC_INC; 0 when !out_valid.
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst_n=0 at edge): count=0, wr_ptr=0, rd_ptr=0.
  - Resulting outputs: out_valid=0, out_* = 0, in_ready=1.
  - Reset has priority over flush, stall and push; all inputs are ignored that cycle.
  - Storage array is not reset; it is masked by count.
- Derived signals:
  - push = in_valid & in_ready & !flush.
  - pop = out_valid & !stall & !flush.
- Push: mem[wr_ptr] <= {in_inst, in_pc, in_pc + PC_INC}; wr_ptr increments modulo DEPTH.
- pc_plus4 arithmetic:
  - Computed at push, XLEN-bit.
  - Wraps modulo 2^XLEN, e.g. 0xFFFFFFFC -> 0x00000000.
- Pop: rd_ptr increments modulo DEPTH.
- Head selection: out_* are selected combinationally from mem[rd_ptr], gated to 0 when count==0.
- Count update: count += push - pop. Simultaneous push and pop leaves count unchanged.
- Latency: an entry pushed at edge N is visible on out_* after edge N. This is one cycle when the queue is empty, the same timing as the previous IF/ID register. There is no same-cycle bypass.
- Ordering: strict FIFO; entries pop in push order.
- Stall:
  - The head is held, with outputs stable for as long as stall=1.
  - Pushes continue while in_ready=1.
  - Stall with empty queue: no effect.
- Flush (rst_n=1):
  - At the edge, count=0 and wr_ptr=rd_ptr=0.
  - Any in_valid that cycle is discarded, not stored.
  - Flush has priority over stall and push.
  - out_valid=0 the next cycle; the following cycle may push again.
- Full (count==DEPTH):
  - in_ready=0, so no push is accepted, even if a pop happens the same cycle.
  - in_ready depends only on count, with no combinational path from stall/flush.
  - in_ready returns to 1 the cycle after the first pop.
- Empty (count==0):
  - out_valid=0, so no pop.
  - A push that cycle gives count=1 after the edge.
- Pointer wrap: wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap naturally. Full vs empty is distinguished by count only.
- Reset mid-operation: all queued entries are dropped; state is identical to post-reset.
- in_inst/in_pc are don't-care when in_valid=0.

Test Plan:
- Reset then single push in_inst=0x00500093, in_pc=0x100 with stall=0 -> one cycle later out_valid=1, out_inst=0x00500093, out_pc=0x100, out_pc_plus4=0x104, count=1; next cycle (no push) out_valid=0, out_*=0.
- Hold stall=1, push 5 entries pc=0x0,0x4,...,0x10 back-to-back with DEPTH=4 -> count reaches 4, in_ready=0, 5th not accepted, out_pc stays 0x0; release stall -> pops 0x0,0x4,0x8,0xC in order; in_ready=1 one cycle after first pop.
- Continuous push+pop at steady state with count=2 -> count stays 2, every pc appears exactly once in order through ≥3 pointer wraps (≥12 entries).
- Queue holds 3 entries, assert flush=1 with in_valid=1 and stall=1 -> next cycle count=0, out_valid=0, flushed-cycle input absent; push pc=0x200 next -> out_pc=0x200 one cycle later.
- Push in_pc=0xFFFFFFFC -> out_pc_plus4=0x00000000.
- Queue holding 2 entries, assert rst_n=0 for one cycle with in_valid=1 -> count=0, out_valid=0, in_ready=1; no entries emerge afterward.
